lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Initiator side of the core's LSU memory port; the responder is the memory/UART model.
- Accepts one load/store from the EXU stage and issues a single-cycle `io_lsu_reqValid` pulse.
- Waits for `io_lsu_respValid`, sign/zero-extends load data by size, and hands the result to the WBU stage through a valid/ready handshake.
- One transaction is in flight at a time; a timeout counter guards against a responder that never answers.

Parameters:
- TIMEOUT, 255, cycles to wait in WAIT for respValid before aborting with an error.
- MISALIGN_CHECK, 1, when 1, misaligned half/word accesses are rejected with out_err and issue no bus request.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  EXU offers a memory op.
- in_ready  out  1  block can accept (IDLE only).
- in_wen  in  1  1=store, 0=load.
- in_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- in_unsigned  in  1  load zero-extends (lbu/lhu).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, LSB-justified.
- out_valid  out  1  result available to WBU.
- out_ready  in  1  WBU accepts result.
- out_rdata  out  32  extended load data; 0 for stores and errors.
- out_err  out  1  transaction aborted (timeout / misaligned / reserved size).
- io_lsu_reqValid  out  1  one-cycle request pulse.
- io_lsu_addr  out  32  request address.
- io_lsu_wen  out  1  write request.
- io_lsu_wdata  out  32  write data, LSB-justified, upper unused bytes zeroed.
- io_lsu_wmask  out  4  byte enables relative to io_lsu_addr.
- io_lsu_size  out  2  copy of in_size.
- io_lsu_rdata  in  32  read data; byte at io_lsu_addr is in [7:0].
- io_lsu_respValid  in  1  responder completion.

Behaviour:
- Reset values:
  - state=IDLE; in_ready=1; all other outputs 0.
  - Timeout counter 0; captured operands 0.
- Lane rules:
  - No byte-lane shifting; the responder aligns to io_lsu_addr.
  - wmask: size 0→4'b0001, size 1→4'b0011, size 2→4'b1111; always 0 for loads.
  - wdata: size 0 keeps [7:0], size 1 keeps [15:0], upper bytes zeroed.
- Load extension:
  - Byte: sign from rdata[7] unless in_unsigned.
  - Half: sign from rdata[15] unless in_unsigned.
  - Word: passes through unchanged.
- FSM, all outputs registered:
  - IDLE:
    - in_ready=1; on in_valid, capture operands.
    - Reserved size, or misaligned with MISALIGN_CHECK=1 (half with addr[0]≠0; word with addr[1:0]≠0) → DONE with err=1, no bus request.
    - Otherwise → REQ.
  - REQ: reqValid=1 with addr/wen/wdata/wmask/size stable for exactly this cycle; counter cleared; → WAIT.
  - WAIT:
    - reqValid=0; counter increments each cycle.
    - On respValid: capture extended rdata (stores: rdata=0), err=0 → DONE.
    - If counter reaches TIMEOUT-1 without respValid: err=1, rdata=0 → DONE.
    - respValid in the same cycle as the terminal count wins (success).
  - DONE:
    - out_valid=1; out_rdata/out_err held stable until out_ready.
    - On out_ready → IDLE (in_ready=1 the following cycle; no same-cycle re-accept).
- Latency: accept at T, reqValid at T+1, earliest respValid at T+2, out_valid at T+3.
- Error path: accept at T, out_valid at T+1.
- respValid outside WAIT (including during REQ) is ignored.
- reset asserted in any state: immediate return to IDLE, reqValid drops asynchronously, in-flight result discarded. A late respValid after reset release is ignored by the IDLE rule.
- reqValid is never asserted for more than one consecutive cycle, so a held request cannot be double-executed by the responder.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W;
  - FSM state enum {IDLE, REQ, WAIT, DONE};
  - wmask-from-size function;
  - MEM_BASE=0x30000000 and SERIAL_PORT=0x10000000 constants for benches.
- One combinational sub-module lsu_load_ext (rdata, size, unsigned → extended data), reused by future cached LSU paths.

Test Plan:
- Load byte at 0x30000010, responder returns 0x00000080 one cycle after reqValid, in_unsigned=0 → out_rdata=0xFFFFFF80, out_err=0, out_valid exactly 3 cycles after accept.
- Load half unsigned at 0x30000012, rdata 0x1234F00D → out_rdata=0x0000F00D; same signed → 0xFFFFF00D.
- Store byte 0x41 at 0x10000000 with in_wdata=0xDEADBE41 → single reqValid pulse, wen=1, wmask=0001, wdata=0x00000041, size=0; out_rdata=0.
- Word load at 0x30000002 with MISALIGN_CHECK=1 → no reqValid ever, out_valid at T+1 with out_err=1.
- Responder silent, TIMEOUT=8 → out_err=1 after 8 WAIT cycles; out_ready held low 5 cycles → outputs stable, in_ready=0 throughout.
- reset driven low mid-WAIT, then respValid pulsed after release → block in IDLE, out_valid never asserts, in_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU bus master: size encodings, FSM states
// and helpers that derive byte enables and store data from the access size.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_R = 2'd3;

  localparam logic [31:0] MEM_BASE    = 32'h3000_0000;
  localparam logic [31:0] SERIAL_PORT = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] wmask_from_size(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] wdata_trim(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] trimmed;
    case (size)
      SZ_B:    trimmed = {24'h00_0000, wdata[7:0]};
      SZ_H:    trimmed = {16'h0000, wdata[15:0]};
      default: trimmed = wdata;
    endcase
    return trimmed;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of LSB-justified load data according to access size.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  // Extend the low byte or half; words and anything else pass through.
  always_comb begin
    ext_data = rdata;
    case (size)
      SZ_B: begin
        if (is_unsigned) ext_data = {24'h00_0000, rdata[7:0]};
        else             ext_data = {{24{rdata[7]}}, rdata[7:0]};
      end
      SZ_H: begin
        if (is_unsigned) ext_data = {16'h0000, rdata[15:0]};
        else             ext_data = {{16{rdata[15]}}, rdata[15:0]};
      end
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU memory-port initiator: one transaction in flight, single-cycle request
// pulse, timeout guard and valid/ready hand-off of the extended result.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT        = 255,
  parameter int MISALIGN_CHECK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        io_lsu_reqValid,
  output logic [31:0] io_lsu_addr,
  output logic        io_lsu_wen,
  output logic [31:0] io_lsu_wdata,
  output logic [3:0]  io_lsu_wmask,
  output logic [1:0]  io_lsu_size,
  input  logic [31:0] io_lsu_rdata,
  input  logic        io_lsu_respValid
);

  localparam int             CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT - 1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          op_unsigned_r;
  logic [31:0]   ext_s;
  logic          bad_s;

  // The io_lsu_* registers double as the captured operands of the transaction.
  lsu_load_ext u_load_ext (
    .rdata       (io_lsu_rdata),
    .size        (io_lsu_size),
    .is_unsigned (op_unsigned_r),
    .ext_data    (ext_s)
  );

  // Reject reserved sizes and, when enabled, misaligned half/word accesses.
  always_comb begin
    if (in_size == SZ_R) begin
      bad_s = 1'b1;
    end else if (MISALIGN_CHECK != 0) begin
      bad_s = misaligned(in_size, in_addr[1:0]);
    end else begin
      bad_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      op_unsigned_r   <= 1'b0;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_rdata       <= 32'h0000_0000;
      out_err         <= 1'b0;
      io_lsu_reqValid <= 1'b0;
      io_lsu_addr     <= 32'h0000_0000;
      io_lsu_wen      <= 1'b0;
      io_lsu_wdata    <= 32'h0000_0000;
      io_lsu_wmask    <= 4'b0000;
      io_lsu_size     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            in_ready      <= 1'b0;
            op_unsigned_r <= in_unsigned;
            if (bad_s) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= 32'h0000_0000;
            end else begin
              state_r         <= REQ;
              io_lsu_reqValid <= 1'b1;
              io_lsu_addr     <= in_addr;
              io_lsu_wen      <= in_wen;
              io_lsu_wdata    <= wdata_trim(in_size, in_wdata);
              io_lsu_wmask    <= in_wen ? wmask_from_size(in_size) : 4'b0000;
              io_lsu_size     <= in_size;
            end
          end
        end
        REQ: begin
          io_lsu_reqValid <= 1'b0;
          cnt_r           <= '0;
          state_r         <= WAIT;
        end
        WAIT: begin
          // A response on the terminal count still counts as success.
          if (io_lsu_respValid) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= io_lsu_wen ? 32'h0000_0000 : ext_s;
          end else if (cnt_r == TERM) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= 32'h0000_0000;
          end
        end
        default: begin
          state_r         <= IDLE;
          in_ready        <= 1'b1;
          out_valid       <= 1'b0;
          out_err         <= 1'b0;
          out_rdata       <= 32'h0000_0000;
          io_lsu_reqValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed and randomized bench for lsu_bus_master against an arithmetic
// model of the load/store rules, with a scripted responder.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  localparam int TO = 8;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, in_wen, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        io_lsu_reqValid, io_lsu_wen, io_lsu_respValid;
  logic [31:0] io_lsu_addr, io_lsu_wdata, io_lsu_rdata;
  logic [3:0]  io_lsu_wmask;
  logic [1:0]  io_lsu_size;

  int checks = 0;
  int errors = 0;

  lsu_bus_master #(.TIMEOUT(TO), .MISALIGN_CHECK(1)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_wen           (in_wen),
    .in_size          (in_size),
    .in_unsigned      (in_unsigned),
    .in_addr          (in_addr),
    .in_wdata         (in_wdata),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rdata        (out_rdata),
    .out_err          (out_err),
    .io_lsu_reqValid  (io_lsu_reqValid),
    .io_lsu_addr      (io_lsu_addr),
    .io_lsu_wen       (io_lsu_wen),
    .io_lsu_wdata     (io_lsu_wdata),
    .io_lsu_wmask     (io_lsu_wmask),
    .io_lsu_size      (io_lsu_size),
    .io_lsu_rdata     (io_lsu_rdata),
    .io_lsu_respValid (io_lsu_respValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference extension: take the low 8<<size bits, subtract 2^bits when signed and negative.
  function automatic logic [31:0] ref_ext(input logic [1:0] size, input logic uns, input logic [31:0] rd);
    longint bits, v;
    if (size == 2'd2) return rd;
    bits = 64'sd8 << size;
    v = longint'(rd) & ((64'sd1 << bits) - 64'sd1);
    if (!uns && v >= (64'sd1 << (bits - 64'sd1))) v = v - (64'sd1 << bits);
    return v[31:0];
  endfunction

  // One transaction. delay = WAIT cycles before respValid; negative or >= TO means silent.
  task automatic do_txn(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                        input int delay, input int hold, input logic noise);
    longint nbytes;
    logic   bad, timed_out;
    logic [31:0] exp_wdata, exp_data;
    logic [3:0]  exp_mask;
    int waits;
    nbytes    = 64'sd1 << size;
    bad       = (size == 2'd3) || ((longint'(addr) % nbytes) != 64'sd0);
    exp_wdata = (size == 2'd2) ? wdata : wdata & 32'((64'sd1 << (nbytes * 64'sd8)) - 64'sd1);
    exp_mask  = wen ? 4'((64'sd1 << nbytes) - 64'sd1) : 4'b0000;
    timed_out = (delay < 0) || (delay >= TO);

    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata;
    @(negedge clock);
    in_valid = 1'b0; in_wen = $urandom; in_size = 2'($urandom); in_unsigned = $urandom;
    in_addr = $urandom; in_wdata = $urandom;
    if (bad) begin
      exp_data = 32'h0000_0000;
      check("err_req",   io_lsu_reqValid, 1'b0);
      check("err_valid", out_valid, 1'b1);
      check("err_flag",  out_err, 1'b1);
      check("err_rdata", out_rdata, 32'h0000_0000);
    end else begin
      check("req_valid", io_lsu_reqValid, 1'b1);
      check("req_addr",  io_lsu_addr, addr);
      check("req_wen",   io_lsu_wen, wen);
      check("req_wdata", io_lsu_wdata, exp_wdata);
      check("req_wmask", io_lsu_wmask, exp_mask);
      check("req_size",  io_lsu_size, size);
      check("req_ovalid", out_valid, 1'b0);
      io_lsu_respValid = noise; io_lsu_rdata = $urandom;
      @(negedge clock);
      io_lsu_respValid = 1'b0;
      waits = timed_out ? TO : delay;
      for (int i = 0; i < waits; i++) begin
        check("wait_req",    io_lsu_reqValid, 1'b0);
        check("wait_ovalid", out_valid, 1'b0);
        @(negedge clock);
      end
      if (!timed_out) begin
        io_lsu_respValid = 1'b1; io_lsu_rdata = rd;
        @(negedge clock);
        io_lsu_respValid = 1'b0; io_lsu_rdata = $urandom;
      end
      exp_data = (timed_out || wen) ? 32'h0000_0000 : ref_ext(size, uns, rd);
      check("done_valid", out_valid, 1'b1);
      check("done_err",   out_err, timed_out);
      check("done_rdata", out_rdata, exp_data);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", out_valid, 1'b1);
      check("hold_err",   out_err, bad || timed_out);
      check("hold_rdata", out_rdata, exp_data);
      check("hold_ready", in_ready, 1'b0);
      check("hold_req",   io_lsu_reqValid, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("ret_ovalid", out_valid, 1'b0);
    check("ret_ready",  in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
    in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b0;
    io_lsu_rdata = 32'h0; io_lsu_respValid = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ovalid",   out_valid, 1'b0);
    check("rst_rdata",    out_rdata, 32'h0);
    check("rst_err",      out_err, 1'b0);
    check("rst_req",      io_lsu_reqValid, 1'b0);
    check("rst_addr",     io_lsu_addr, 32'h0);
    check("rst_wmask",    io_lsu_wmask, 4'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    check("model_lb", ref_ext(2'd0, 1'b0, 32'h0000_0080), 32'hFFFF_FF80);
    do_txn(1'b0, 2'd0, 1'b0, MEM_BASE + 32'h10, 32'h0, 32'h0000_0080, 0, 0, 1'b0);
    do_txn(1'b0, 2'd1, 1'b1, MEM_BASE + 32'h12, 32'h0, 32'h1234_F00D, 0, 1, 1'b0);
    do_txn(1'b0, 2'd1, 1'b0, MEM_BASE + 32'h12, 32'h0, 32'h1234_F00D, 2, 0, 1'b1);
    do_txn(1'b1, 2'd0, 1'b0, SERIAL_PORT, 32'hDEAD_BE41, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_txn(1'b0, 2'd2, 1'b0, MEM_BASE + 32'h2, 32'h0, 32'h0, 0, 2, 1'b0);
    do_txn(1'b0, 2'd2, 1'b0, MEM_BASE + 32'h4, 32'h0, 32'h0, -1, 5, 1'b0);
    do_txn(1'b0, 2'd2, 1'b0, MEM_BASE + 32'h8, 32'h0, 32'hCAFE_F00D, TO - 1, 0, 1'b0);
    do_txn(1'b1, 2'd3, 1'b0, MEM_BASE, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
    do_txn(1'b1, 2'd1, 1'b0, MEM_BASE + 32'h6, 32'hAAAA_8001, 32'h0, 1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic w;
      w = 1'($urandom);
      do_txn(w, 2'($urandom), 1'($urandom),
             (w ? SERIAL_PORT : MEM_BASE) + 32'($urandom_range(0, 255)),
             $urandom, $urandom, int'($urandom_range(0, TO)), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    // Reset during REQ must drop the request pulse without waiting for a clock.
    in_valid = 1'b1; in_wen = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
    in_addr = MEM_BASE; in_wdata = 32'h0;
    @(negedge clock);
    in_valid = 1'b0;
    check("rq_req_before", io_lsu_reqValid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rq_req_async", io_lsu_reqValid, 1'b0);
    check("rq_in_ready",  in_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset mid-WAIT followed by a stale response.
    in_valid = 1'b1; in_addr = MEM_BASE + 32'h20;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rw_in_ready", in_ready, 1'b1);
    check("rw_ovalid",   out_valid, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h5555_5555;
    @(negedge clock);
    io_lsu_respValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rw_late_ovalid", out_valid, 1'b0);
      check("rw_late_ready",  in_ready, 1'b1);
      check("rw_late_req",    io_lsu_reqValid, 1'b0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
